// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the PSRAM arbiter: the FSM state encoding, the
//   fixed requester indices and the "no owner" grant code.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESPOND,
      RELEASE
   } arb_state_e;

   // Requester slots; the picker's priority order depends on these values.
   localparam logic [1:0] REQ_VIC    = 2'd0;
   localparam logic [1:0] REQ_CPU    = 2'd1;
   localparam logic [1:0] REQ_LOADER = 2'd2;
   localparam logic [1:0] GRANT_NONE = 2'd3;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/mem_arb_picker.sv
// ---------------------------------------------------------------------------
// mem_arb_picker
//   Combinational winner selection. The VIC always wins; the CPU and the
//   loader share the remaining bandwidth round-robin.
//
// Ports
//   req_i        in   3  request vector (index = requester id)
//   rr_loader_i  in   1  1 = loader preferred on a CPU/loader tie
//   winner_o     out  2  selected requester id (GRANT_NONE when none)
//   valid_o      out  1  at least one request present
// ---------------------------------------------------------------------------
module mem_arb_picker
   import mem_arbiter_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic       rr_loader_i,
   output logic [1:0] winner_o,
   output logic       valid_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      winner_o = GRANT_NONE;
      valid_o  = 1'b1;
      if (req_i[REQ_VIC]) begin
         winner_o = REQ_VIC;
      end else if (req_i[REQ_CPU] && req_i[REQ_LOADER]) begin
         winner_o = rr_loader_i ? REQ_LOADER : REQ_CPU;
      end else if (req_i[REQ_CPU]) begin
         winner_o = REQ_CPU;
      end else if (req_i[REQ_LOADER]) begin
         winner_o = REQ_LOADER;
      end else begin
         valid_o = 1'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Serialises three requesters (VIC, CPU, loader) onto one PSRAM controller
//   port. One transaction at a time: the winner's fields are latched, cs is
//   held low while the controller is busy, the owner gets a one-cycle ack and
//   cs returns high for at least one cycle so the controller sees a new edge.
//
// Build option
//   MEM_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transaction that
//                       waits TIMEOUT_CYCLES on the controller and sets the
//                       sticky o_err (no ack is given). Undefined: no
//                       watchdog, o_err is tied low.
//
// Ports
//   i_clkRAM          in   1   RAM clock
//   reset             in   1   asynchronous active-low reset
//   i_req/i_we/i_bank in   3   per-requester request, write, bank
//   i_addr            in   72  requester k at [24k+23:24k]
//   i_wdata           in   24  requester k at [8k+7:8k]
//   o_ack             out  3   one-cycle completion pulse
//   o_rdata           out  8   last read byte
//   o_grant           out  2   current owner, 3 when idle
//   o_err             out  1   sticky timeout flag
//   o_mem_*           out      chip-select (active-low) and latched fields
//   i_mem_busy, i_mem_dataReady, i_mem_rdata  in  controller status/data
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned NREQ           = 3
) (
   input  logic                     i_clkRAM,
   input  logic                     reset,
   input  logic [NREQ-1:0]          i_req,
   input  logic [NREQ-1:0]          i_we,
   input  logic [ADDR_W*NREQ-1:0]   i_addr,
   input  logic [NREQ-1:0]          i_bank,
   input  logic [DATA_W*NREQ-1:0]   i_wdata,
   output logic [NREQ-1:0]          o_ack,
   output logic [DATA_W-1:0]        o_rdata,
   output logic [1:0]               o_grant,
   output logic                     o_err,
   output logic                     o_mem_cs,
   output logic                     o_mem_write,
   output logic [ADDR_W-1:0]        o_mem_address,
   output logic                     o_mem_bank,
   output logic [DATA_W-1:0]        o_mem_wdata,
   input  logic                     i_mem_busy,
   input  logic                     i_mem_dataReady,
   input  logic [DATA_W-1:0]        i_mem_rdata
);

   arb_state_e        state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic              rr_loader_q, rr_loader_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              bank_q, bank_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [1:0]        pick_winner;
   logic              pick_valid;
   logic              timeout_fire;
   logic              unused_ok;

   mem_arb_picker u_picker (
      .req_i       (i_req),
      .rr_loader_i (rr_loader_q),
      .winner_o    (pick_winner),
      .valid_o     (pick_valid)
   );

   // ------------------------------------------------------------------------
   // Optional watchdog. The count spans both wait states so the limit covers
   // the whole time spent waiting on the controller.
   // ------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;

   assign timeout_fire = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                         (((state_q == WAIT_BUSY) && !i_mem_busy) ||
                          ((state_q == WAIT_DONE) &&  i_mem_busy));
   assign wait_cnt_d   = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE))
                         ? wait_cnt_q + 1'b1 : '0;
   assign err_d        = err_q | timeout_fire;

   always_ff @(posedge i_clkRAM or negedge reset) begin
      if (!reset) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign o_err     = err_q;
   // dataReady duplicates the falling edge of busy for this controller.
   assign unused_ok = i_mem_dataReady;
`else
   assign timeout_fire = 1'b0;
   assign o_err        = 1'b0;
   assign unused_ok    = i_mem_dataReady | (TIMEOUT_CYCLES == 0);
`endif

   // ------------------------------------------------------------------------
   // State and transaction registers
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clkRAM or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= GRANT_NONE;
         rr_loader_q <= 1'b0;
         rdata_q     <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         bank_q      <= 1'b0;
         wdata_q     <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples
         // the pre-edge values regardless of statement order.
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_loader_q <= rr_loader_d;
         rdata_q     <= rdata_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         bank_q      <= bank_d;
         wdata_q     <= wdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_loader_d = rr_loader_q;
      rdata_d     = rdata_q;
      write_d     = write_q;
      addr_d      = addr_q;
      bank_d      = bank_q;
      wdata_d     = wdata_q;
      o_mem_cs    = 1'b1;
      o_ack       = '0;

      case (state_q)
         IDLE: begin
            // A busy controller (e.g. still initialising) blocks any grant.
            if (!i_mem_busy && pick_valid) begin
               owner_d = pick_winner;
               write_d = i_we[pick_winner];
               addr_d  = i_addr[ADDR_W*pick_winner +: ADDR_W];
               bank_d  = i_bank[pick_winner];
               wdata_d = i_wdata[DATA_W*pick_winner +: DATA_W];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            o_mem_cs = 1'b0;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            o_mem_cs = 1'b0;
            if (i_mem_busy) begin
               state_d = WAIT_DONE;
            end else if (timeout_fire) begin
               state_d = RELEASE;
            end
         end
         WAIT_DONE: begin
            o_mem_cs = 1'b0;
            if (!i_mem_busy) begin
               if (!write_q) begin
                  rdata_d = i_mem_rdata;
               end
               state_d = RESPOND;
            end else if (timeout_fire) begin
               state_d = RELEASE;
            end
         end
         RESPOND: begin
            o_mem_cs       = 1'b0;
            o_ack[owner_q] = 1'b1;
            // Whoever of CPU/loader was just served loses the next tie.
            if (owner_q == REQ_CPU) begin
               rr_loader_d = 1'b1;
            end else if (owner_q == REQ_LOADER) begin
               rr_loader_d = 1'b0;
            end
            state_d = RELEASE;
         end
         RELEASE: begin
            owner_d = GRANT_NONE;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_grant       = owner_q;
   assign o_rdata       = rdata_q;
   assign o_mem_write   = write_q;
   assign o_mem_address = addr_q;
   assign o_mem_bank    = bank_q;
   assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small behavioural PSRAM controller:
//   on each falling cs edge it raises busy for busy_len cycles and presents
//   model_rdata. The MEM_ARB_TIMEOUT_EN scenario is compiled in only when the
//   macro is defined; otherwise o_err is checked to stay low.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int TMO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int FIRST_BUSY = 10;
`else
   localparam int FIRST_BUSY = 20;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  req = '0, we = '0, bank = '0;
   logic [71:0] addr = '0;
   logic [23:0] wdata = '0;
   logic [2:0]  ack;
   logic [7:0]  rdata;
   logic [1:0]  grant;
   logic        err;
   logic        mem_cs, mem_write, mem_bank;
   logic [23:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_busy, mem_ready;
   logic [7:0]  mem_rdata;

   // controller model
   logic        model_busy = 1'b0, force_busy = 1'b0, model_dead = 1'b0;
   logic        cs_prev = 1'b1;
   int          busy_len = 20, busy_left = 0;
   logic [7:0]  model_rdata = '0;

   // monitor
   int          n_cmp = 0, n_bad = 0;
   int          win_cnt = 0, gap_cur = 1000, gap_min = 1000, field_bad = 0;
   int          ack_cnt [3] = '{0, 0, 0};
   logic [1:0]  grant_log [$];
   int          ack_order [$];
   logic        cs_last_mon = 1'b1, chk_fields = 1'b0;
   logic        exp_write = 1'b0, exp_bank = 1'b0;
   logic [23:0] exp_addr = '0;
   logic [7:0]  exp_wdata = '0;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO), .NREQ(3)) dut (
      .i_clkRAM        (clk),
      .reset           (reset),
      .i_req           (req),
      .i_we            (we),
      .i_addr          (addr),
      .i_bank          (bank),
      .i_wdata         (wdata),
      .o_ack           (ack),
      .o_rdata         (rdata),
      .o_grant         (grant),
      .o_err           (err),
      .o_mem_cs        (mem_cs),
      .o_mem_write     (mem_write),
      .o_mem_address   (mem_address),
      .o_mem_bank      (mem_bank),
      .o_mem_wdata     (mem_wdata),
      .i_mem_busy      (mem_busy),
      .i_mem_dataReady (mem_ready),
      .i_mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_busy  = model_busy | force_busy;
   assign mem_rdata = model_rdata;

   logic ready_q = 1'b0;
   assign mem_ready = ready_q;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_busy <= 1'b0;
         cs_prev    <= 1'b1;
         busy_left  <= 0;
         ready_q    <= 1'b0;
      end else begin
         cs_prev <= mem_cs;
         ready_q <= 1'b0;
         if (!mem_cs && cs_prev && !model_dead) begin
            model_busy <= 1'b1;
            busy_left  <= busy_len;
         end else if (model_busy) begin
            if (busy_left <= 1) begin
               model_busy <= 1'b0;
               ready_q    <= 1'b1;
            end else begin
               busy_left <= busy_left - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (!mem_cs && cs_last_mon) begin
            win_cnt++;
            grant_log.push_back(grant);
            if (gap_cur < gap_min) gap_min = gap_cur;
         end
         gap_cur = mem_cs ? gap_cur + 1 : 0;
         for (int k = 0; k < 3; k++) if (ack[k]) ack_cnt[k]++;
         if (chk_fields && !mem_cs &&
             ({mem_write, mem_address, mem_bank, mem_wdata} !==
              {exp_write, exp_addr, exp_bank, exp_wdata}))
            field_bad++;
      end
      cs_last_mon = mem_cs;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic w, input logic [23:0] a,
                          input logic b, input logic [7:0] d);
      we[k]             = w;
      addr[24*k +: 24]  = a;
      bank[k]           = b;
      wdata[8*k +: 8]   = d;
      req[k]            = 1'b1;
   endtask

   // Waits for an ack from every requester in mask, dropping each request on
   // its own ack; ack order is logged.
   task automatic serve(input string tag, input logic [2:0] mask, input int budget);
      logic [2:0] pend;
      int         n;
      pend = mask;
      n    = 0;
      while (pend != 3'b000 && n < budget) begin
         step();
         n++;
         for (int k = 0; k < 3; k++) begin
            if (pend[k] && ack[k]) begin
               req[k]  = 1'b0;
               pend[k] = 1'b0;
               ack_order.push_back(k);
            end
         end
      end
      check({tag, "_acked"}, pend, 3'b000);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"},     mem_cs, 1'b1);
      check({tag, "_ack"},    ack,    3'b000);
      check({tag, "_grant"},  grant,  2'd3);
      check({tag, "_rdata"},  rdata,  8'h00);
      check({tag, "_err"},    err,    1'b0);
      check({tag, "_fields"}, {mem_write, mem_address, mem_bank, mem_wdata}, 34'd0);
   endtask

   int bad, n, lows, acks_before, total_acks;

   initial begin
      // ---------------- reset state ----------------
      force_busy = 1'b1;
      repeat (3) step();
      check_reset_outputs("rst");
      reset = 1'b1;
      step();

      // ---------------- start-up busy, then single CPU read ----------------
      set_req(1, 1'b0, 24'h012345, 1'b0, 8'h00);
      model_rdata = 8'hA5;
      busy_len    = FIRST_BUSY;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (grant != 2'd3 || mem_cs != 1'b1) bad++;
      end
      check("startup_hold", bad, 0);
      {exp_write, exp_addr, exp_bank, exp_wdata} = {1'b0, 24'h012345, 1'b0, 8'h00};
      chk_fields = 1'b1;
      force_busy = 1'b0;
      serve("cpu_read", 3'b010, 200);
      check("cpu_read_ack_cnt", ack_cnt[1], 1);
      check("cpu_read_other_acks", ack_cnt[0] + ack_cnt[2], 0);
      check("cpu_read_rdata", rdata, 8'hA5);
      check("cpu_read_fields_stable", field_bad, 0);
      step();
      check("cpu_read_release_cs", mem_cs, 1'b1);
      check("cpu_read_release_ack", ack, 3'b000);
      step();
      check("cpu_read_idle_grant", grant, 2'd3);
      check("cpu_read_windows", win_cnt, 1);
      chk_fields = 1'b0;

      // ---------------- VIC and CPU in the same cycle ----------------
      win_cnt = 0; gap_min = 1000; gap_cur = 1000;
      grant_log.delete(); ack_order.delete();
      busy_len = 3; model_rdata = 8'h11;
      set_req(0, 1'b0, 24'h000100, 1'b0, 8'h00);
      set_req(1, 1'b0, 24'h000200, 1'b0, 8'h00);
      serve("vic_cpu", 3'b011, 200);
      check("vic_cpu_ack_n", ack_order.size(), 2);
      check("vic_cpu_first_ack", ack_order[0], 0);
      check("vic_cpu_second_ack", ack_order[1], 1);
      check("vic_cpu_windows", win_cnt, 2);
      check("vic_cpu_grant0", grant_log[0], 2'd0);
      check("vic_cpu_grant1", grant_log[1], 2'd1);
      check("vic_cpu_cs_gap", gap_min >= 1, 1'b1);

      // ---------------- loader write at top address, bank 1 ----------------
      field_bad = 0; win_cnt = 0;
      model_rdata = 8'hEE;
      set_req(2, 1'b1, 24'h3FFFFF, 1'b1, 8'h5A);
      {exp_write, exp_addr, exp_bank, exp_wdata} = {1'b1, 24'h3FFFFF, 1'b1, 8'h5A};
      chk_fields = 1'b1;
      serve("ldr_write", 3'b100, 200);
      check("ldr_write_fields_stable", field_bad, 0);
      check("ldr_write_windows", win_cnt, 1);
      check("ldr_write_rdata_kept", rdata, 8'h11);
      step();
      check("ldr_write_release_cs", mem_cs, 1'b1);
      check("ldr_write_release_fields", {mem_write, mem_address, mem_bank, mem_wdata},
            {1'b1, 24'h3FFFFF, 1'b1, 8'h5A});
      chk_fields = 1'b0;
      step();

      // ---------------- CPU + loader continuous: 1,2,1,2,1,2 ----------------
      grant_log.delete();
      busy_len = 2;
      set_req(1, 1'b0, 24'h000010, 1'b0, 8'h00);
      set_req(2, 1'b1, 24'h000020, 1'b0, 8'h33);
      n = 0; total_acks = 0;
      while (total_acks < 6 && n < 400) begin
         step();
         n++;
         if (ack[1]) total_acks++;
         if (ack[2]) total_acks++;
      end
      req = 3'b000;
      repeat (4) step();
      check("rr_acks", total_acks, 6);
      check("rr_grants_n", grant_log.size(), 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("rr_grant%0d", i), grant_log[i], (i % 2 == 0) ? 2'd1 : 2'd2);

      // ---------------- request dropped after grant still completes ----------
      busy_len = 5; model_rdata = 8'h77;
      acks_before = ack_cnt[0];
      set_req(0, 1'b0, 24'h000ABC, 1'b0, 8'h00);
      n = 0;
      while (grant != 2'd0 && n < 20) begin step(); n++; end
      check("drop_granted", grant, 2'd0);
      req[0] = 1'b0;
      n = 0;
      while (!ack[0] && n < 50) begin step(); n++; end
      check("drop_still_acked", ack[0], 1'b1);
      check("drop_rdata", rdata, 8'h77);
      repeat (3) step();
      check("drop_single_ack", ack_cnt[0] - acks_before, 1);

`ifdef MEM_ARB_TIMEOUT_EN
      // ---------------- controller never responds ----------------
      model_dead = 1'b1;
      acks_before = ack_cnt[0] + ack_cnt[1] + ack_cnt[2];
      set_req(1, 1'b0, 24'h000ABC, 1'b0, 8'h00);
      n = 0;
      while (grant != 2'd1 && n < 20) begin step(); n++; end
      check("tmo_err_before", err, 1'b0);
      lows = 0; n = 0;
      while (!mem_cs && n < 100) begin lows++; step(); n++; end
      req[1] = 1'b0;
      // ISSUE plus TMO waiting cycles with cs low
      check("tmo_cs_low_cycles", lows, TMO + 1);
      check("tmo_err_set", err, 1'b1);
      check("tmo_no_ack", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] - acks_before, 0);
      step();
      check("tmo_back_idle", grant, 2'd3);
      model_dead = 1'b0; busy_len = 2; model_rdata = 8'h55;
      set_req(2, 1'b0, 24'h000001, 1'b0, 8'h00);
      serve("tmo_next", 3'b100, 100);
      check("tmo_next_rdata", rdata, 8'h55);
      check("tmo_err_sticky", err, 1'b1);
`else
      check("no_tmo_err_low", err, 1'b0);
`endif

      // ---------------- reset during WAIT_DONE ----------------
      busy_len = 20; model_rdata = 8'h99;
      set_req(1, 1'b0, 24'h0000F0, 1'b0, 8'h00);
      n = 0;
      while (grant != 2'd1 && n < 20) begin step(); n++; end
      repeat (6) step();
      check("rst_mid_busy", mem_busy, 1'b1);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      req[1] = 1'b0;
      acks_before = ack_cnt[0] + ack_cnt[1] + ack_cnt[2];
      step(); step();
      reset = 1'b1;
      repeat (30) step();
      check("rst_mid_no_ack", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] - acks_before, 0);
      check("rst_mid_idle", grant, 2'd3);
      busy_len = 4; model_rdata = 8'h3C;
      set_req(1, 1'b0, 24'h000123, 1'b0, 8'h00);
      serve("rst_after", 3'b010, 100);
      check("rst_after_rdata", rdata, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
